// File: rtl/branch_verify_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_verify_unit_pkg
// Purpose  : Shared types and constants for the branch verify path: BHT entry
//            layout, branch-type encoding, prediction record, verify result
//            (field order matches the BPU verify bus) and FSM states.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package branch_verify_unit_pkg;

  localparam int          BHT_ENTRY_W     = 58;
  localparam logic [31:0] FALLTHRU_OFFSET = 32'd8;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_COND = 3'd1,
    BR_JUMP = 3'd2,
    BR_CALL = 3'd3,
    BR_RET  = 3'd4,
    BR_IND  = 3'd5
  } br_type_e;

  typedef struct packed {
    logic [20:0] tag;
    logic [31:0] target;
    br_type_e    br_type;
    logic [1:0]  count;
  } BHT_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    BHT_entry_t  entry;
  } pred_rec_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] pc;
    logic        success;
    logic        taken;
    logic [31:0] target;
    BHT_entry_t  entry;
  } verify_result_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Next sequential PC for a not-taken branch (fetch bundles are 8 bytes).
  function automatic logic [31:0] fallthrough_pc(input logic [31:0] pc);
    return pc + FALLTHRU_OFFSET;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_verify_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_verify_unit_if
// Purpose  : Bundles the prediction, resolution, verify and perf signals of
//            the branch verify unit.
// Ports    : pred_* (fetch -> unit), res_* (execute -> unit),
//            vfy_*/flush (unit -> BPU/pipe), perf_* counters.
//            master = fetch/execute/BPU side, slave = branch_verify_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_verify_unit_if #(
  parameter int ENTRY_W = branch_verify_unit_pkg::BHT_ENTRY_W
) ();

  logic               pred_valid;
  logic               pred_ready;
  logic [31:0]        pred_pc;
  logic               pred_taken;
  logic [31:0]        pred_target;
  logic [ENTRY_W-1:0] pred_entry;

  logic               res_valid;
  logic               res_ready;
  logic               res_taken;
  logic [31:0]        res_target;

  logic               vfy_ready;
  logic [31:0]        vfy_pc;
  logic               vfy_success;
  logic               vfy_taken;
  logic [31:0]        vfy_target;
  logic [ENTRY_W-1:0] vfy_entry;
  logic               flush;

  logic [31:0]        perf_branches;
  logic [31:0]        perf_mispredicts;

  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target, pred_entry,
    output res_valid, res_taken, res_target,
    input  pred_ready, res_ready,
    input  vfy_ready, vfy_pc, vfy_success, vfy_taken, vfy_target, vfy_entry,
    input  flush, perf_branches, perf_mispredicts
  );

  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target, pred_entry,
    input  res_valid, res_taken, res_target,
    output pred_ready, res_ready,
    output vfy_ready, vfy_pc, vfy_success, vfy_taken, vfy_target, vfy_entry,
    output flush, perf_branches, perf_mispredicts
  );

endinterface
`default_nettype wire

// File: rtl/branch_info_fifo.sv
`default_nettype none
// ============================================================================
// Module   : branch_info_fifo
// Purpose  : Circular queue of prediction records. Pointers carry an extra
//            wrap bit so full/empty are distinguishable. flush_to_head pops
//            the head and discards every younger entry in the same cycle.
// Ports    : clk, reset (sync, active-high)
//            push/push_data, pop, flush_to_head -> control
//            head_data, full, empty           -> status
// Revision : 1.0 - initial release
// ============================================================================
module branch_info_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 123
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush_to_head,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      w_rd_next;
  logic [AW:0]      w_wr_next;

  assign w_rd_next = r_rd_ptr + (AW+1)'(1);
  assign w_wr_next = r_wr_ptr + (AW+1)'(1);

  assign full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign head_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush_to_head) begin
      // Head consumed and everything behind it dropped: queue becomes empty.
      r_rd_ptr <= w_rd_next;
      r_wr_ptr <= w_rd_next;
    end else begin
      if (pop)  r_rd_ptr <= w_rd_next;
      if (push) r_wr_ptr <= w_wr_next;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push && !flush_to_head) begin
      r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_verify_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_verify_unit
// Purpose  : Queues BPU prediction records, compares the oldest one against
//            the execute-stage resolution, drives the verify bus back to the
//            BPU and flushes the pipe on a mispredict (followed by a single
//            HOLD cycle).
// Ports    : clk, reset (sync, active-high)
//            bus (slave modport): pred_* in, pred_ready out; res_* in,
//            res_ready out; vfy_*, flush, perf_* out.
// Revision : 1.0 - initial release
// ============================================================================
module branch_verify_unit
  import branch_verify_unit_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = BHT_ENTRY_W
) (
  input  logic                clk,
  input  logic                reset,
  branch_verify_unit_if.slave bus
);

  localparam int REC_W = 32 + 1 + 32 + ENTRY_W;

  state_t             r_state;
  state_t             w_state_next;

  logic [REC_W-1:0]   w_push_rec;
  logic [REC_W-1:0]   w_head_rec;
  logic               w_full;
  logic               w_empty;
  logic               w_pred_ready;
  logic               w_res_ready;
  logic               w_pred_acc;
  logic               w_res_acc;
  logic               w_success;
  logic               w_mispredict;
  logic [31:0]        w_correct_target;

  logic [31:0]        w_head_pc;
  logic               w_head_taken;
  logic [31:0]        w_head_target;
  logic [ENTRY_W-1:0] w_head_entry;

  logic               r_vfy_ready;
  logic [31:0]        r_vfy_pc;
  logic               r_vfy_success;
  logic               r_vfy_taken;
  logic [31:0]        r_vfy_target;
  logic [ENTRY_W-1:0] r_vfy_entry;
  logic               r_flush;
  logic [31:0]        r_perf_branches;
  logic [31:0]        r_perf_mispredicts;

  // ---------------------------------------------------------------- queue
  assign w_push_rec = {bus.pred_pc, bus.pred_taken, bus.pred_target, bus.pred_entry};

  assign w_head_pc     = w_head_rec[REC_W-1 -: 32];
  assign w_head_taken  = w_head_rec[REC_W-33];
  assign w_head_target = w_head_rec[REC_W-34 -: 32];
  assign w_head_entry  = w_head_rec[ENTRY_W-1:0];

  branch_info_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .push          (w_pred_acc && !w_mispredict),  // wrong-path record dropped
    .push_data     (w_push_rec),
    .pop           (w_res_acc),
    .flush_to_head (w_mispredict),
    .head_data     (w_head_rec),
    .full          (w_full),
    .empty         (w_empty)
  );

  // ------------------------------------------------------------ handshake
  assign w_pred_ready = !w_full  && (r_state == IDLE);
  assign w_res_ready  = !w_empty && (r_state == IDLE);
  assign w_pred_acc   = bus.pred_valid && w_pred_ready;
  assign w_res_acc    = bus.res_valid  && w_res_ready;

  assign bus.pred_ready = w_pred_ready;
  assign bus.res_ready  = w_res_ready;

  // -------------------------------------------------------------- compare
  // Target only matters when the branch was actually taken.
  assign w_success = (w_head_taken == bus.res_taken) &&
                     (!bus.res_taken || (w_head_target == bus.res_target));
  assign w_mispredict     = w_res_acc && !w_success;
  assign w_correct_target = bus.res_taken ? bus.res_target : fallthrough_pc(w_head_pc);

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_mispredict) w_state_next = HOLD;
      HOLD:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ------------------------------------------------- results and counters
  // Counters advance together with the registered result so they already
  // include the branch shown on the verify bus in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vfy_ready        <= 1'b0;
      r_vfy_pc           <= '0;
      r_vfy_success      <= 1'b0;
      r_vfy_taken        <= 1'b0;
      r_vfy_target       <= '0;
      r_vfy_entry        <= '0;
      r_flush            <= 1'b0;
      r_perf_branches    <= '0;
      r_perf_mispredicts <= '0;
    end else begin
      r_vfy_ready <= w_res_acc;
      r_flush     <= w_mispredict;
      if (w_res_acc) begin
        r_vfy_pc        <= w_head_pc;
        r_vfy_success   <= w_success;
        r_vfy_taken     <= bus.res_taken;
        r_vfy_target    <= w_correct_target;
        r_vfy_entry     <= w_head_entry;
        r_perf_branches <= r_perf_branches + 32'd1;
        if (!w_success) r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
      end
    end
  end

  assign bus.vfy_ready        = r_vfy_ready;
  assign bus.vfy_pc           = r_vfy_pc;
  assign bus.vfy_success      = r_vfy_success;
  assign bus.vfy_taken        = r_vfy_taken;
  assign bus.vfy_target       = r_vfy_target;
  assign bus.vfy_entry        = r_vfy_entry;
  assign bus.flush            = r_flush;
  assign bus.perf_branches    = r_perf_branches;
  assign bus.perf_mispredicts = r_perf_mispredicts;

endmodule
`default_nettype wire

// File: tb/tb_branch_verify_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_verify_unit
// Purpose  : Self-checking bench for branch_verify_unit. A queue-based model
//            tracks outstanding predictions and the expected verify bus.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_verify_unit;

  localparam int DEPTH   = 8;
  localparam int ENTRY_W = 58;

  typedef struct packed {
    logic [31:0]        pc;
    logic               taken;
    logic [31:0]        target;
    logic [ENTRY_W-1:0] entry;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_verify_unit_if #(.ENTRY_W(ENTRY_W)) bus ();

  branch_verify_unit #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Model state
  rec_t               q[$];
  bit                 m_hold;
  logic               e_vfy_ready, e_success, e_taken, e_flush;
  logic [31:0]        e_pc, e_target, e_br, e_mp;
  logic [ENTRY_W-1:0] e_entry;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t mk(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    rec_t r;
    r.pc     = pc;
    r.taken  = tk;
    r.target = tg;
    r.entry  = ENTRY_W'({$urandom, $urandom});
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_hold = 0;
    e_vfy_ready = 0; e_success = 0; e_taken = 0; e_flush = 0;
    e_pc = 0; e_target = 0; e_br = 0; e_mp = 0; e_entry = '0;
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_vfy_ready"},   bus.vfy_ready,        e_vfy_ready);
    chk({pfx, "_flush"},       bus.flush,            e_flush);
    chk({pfx, "_vfy_pc"},      bus.vfy_pc,           e_pc);
    chk({pfx, "_vfy_success"}, bus.vfy_success,      e_success);
    chk({pfx, "_vfy_taken"},   bus.vfy_taken,        e_taken);
    chk({pfx, "_vfy_target"},  bus.vfy_target,       e_target);
    chk({pfx, "_vfy_entry"},   bus.vfy_entry,        e_entry);
    chk({pfx, "_perf_br"},     bus.perf_branches,    e_br);
    chk({pfx, "_perf_mp"},     bus.perf_mispredicts, e_mp);
  endtask

  // One clock cycle: drive inputs, check readies, then check results after the edge.
  task automatic step(input bit pv, input rec_t r, input bit rv, input logic rt,
                      input logic [31:0] rtg, input bit rst);
    bit   exp_pr, exp_rr, acc_p, acc_r, ok;
    rec_t h;
    @(negedge clk);
    reset           = rst;
    bus.pred_valid  = pv;
    bus.pred_pc     = r.pc;
    bus.pred_taken  = r.taken;
    bus.pred_target = r.target;
    bus.pred_entry  = r.entry;
    bus.res_valid   = rv;
    bus.res_taken   = rt;
    bus.res_target  = rtg;
    exp_pr = !m_hold && (q.size() < DEPTH);
    exp_rr = !m_hold && (q.size() > 0);
    #1;
    chk("pred_ready", bus.pred_ready, exp_pr);
    chk("res_ready",  bus.res_ready,  exp_rr);
    acc_p = pv && exp_pr;
    acc_r = rv && exp_rr;
    ok    = 1;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (acc_r) begin
        h  = q.pop_front();
        ok = (h.taken == rt) && (!rt || (h.target == rtg));
        e_vfy_ready = 1;
        e_pc        = h.pc;
        e_success   = ok;
        e_taken     = rt;
        e_target    = rt ? rtg : h.pc + 32'd8;
        e_entry     = h.entry;
        e_flush     = !ok;
        e_br        = e_br + 1;
        if (!ok) begin
          e_mp = e_mp + 1;
          q.delete();
        end
        m_hold = !ok;
      end else begin
        e_vfy_ready = 0;
        e_flush     = 0;
        m_hold      = 0;
      end
      if (acc_p && ok) q.push_back(r);
    end
    check_outputs("cyc");
  endtask

  rec_t nul;

  initial begin
    nul = '0;
    reset = 1;
    bus.pred_valid = 0; bus.pred_pc = 0; bus.pred_taken = 0; bus.pred_target = 0;
    bus.pred_entry = '0; bus.res_valid = 0; bus.res_taken = 0; bus.res_target = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pred_ready", bus.pred_ready, 1);
    chk("rst_res_ready",  bus.res_ready,  0);
    check_outputs("rst");

    // Correct not-taken
    step(1, mk(32'h1000, 0, 32'h0), 0, 0, 0, 0);
    step(0, nul, 1, 0, 32'h0, 0);
    chk("t1_vfy_ready", bus.vfy_ready, 1);
    chk("t1_success",   bus.vfy_success, 1);
    chk("t1_target",    bus.vfy_target, 32'h1008);
    chk("t1_flush",     bus.flush, 0);
    chk("t1_perf_br",   bus.perf_branches, 1);
    step(0, nul, 0, 0, 0, 0);

    // Wrong target
    step(1, mk(32'h2000, 1, 32'h3000), 0, 0, 0, 0);
    step(0, nul, 1, 1, 32'h3400, 0);
    chk("t2_success",  bus.vfy_success, 0);
    chk("t2_target",   bus.vfy_target, 32'h3400);
    chk("t2_flush",    bus.flush, 1);
    chk("t2_pred_rdy", bus.pred_ready, 0);
    chk("t2_res_rdy",  bus.res_ready, 0);
    chk("t2_perf_mp",  bus.perf_mispredicts, 1);
    step(0, nul, 0, 0, 0, 0);
    chk("t2_pred_rdy_back", bus.pred_ready, 1);

    // Flush younger entries, plus a wrong-path push in the resolve cycle
    for (int i = 0; i < 3; i++) step(1, mk(32'h4000 + 32'(i*16), 0, 32'h0), 0, 0, 0, 0);
    step(1, mk(32'h5000, 0, 0), 1, 1, 32'h6000, 0);
    chk("t3_flush", bus.flush, 1);
    step(1, mk(32'h5100, 0, 0), 0, 0, 0, 0);  // HOLD: refused
    step(0, nul, 1, 0, 0, 0);
    chk("t3_res_rdy_empty", bus.res_ready, 0);

    // Full, then refill and wrap pointers
    for (int i = 0; i < DEPTH; i++) step(1, mk(32'h7000 + 32'(i*4), 0, 0), 0, 0, 0, 0);
    step(1, mk(32'h7F00, 0, 0), 0, 0, 0, 0);
    chk("t4_full_pred_rdy", bus.pred_ready, 0);
    step(0, nul, 1, 0, 0, 0);
    chk("t4_after_pop_rdy", bus.pred_ready, 1);
    for (int i = 0; i < 20; i++) step(1, mk(32'h8000 + 32'(i*4), 0, 0), 1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, nul, 1, 0, 0, 0);

    // Back-to-back correct resolves
    for (int i = 0; i < 4; i++) step(1, mk(32'h9000 + 32'(i*8), 1, 32'hA000 + 32'(i)), 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, nul, 1, 1, 32'hA000 + 32'(i), 0);
      chk("t5_b2b_vfy", bus.vfy_ready, 1);
    end
    step(0, nul, 0, 0, 0, 0);

    // Reset during HOLD
    step(1, mk(32'hB000, 0, 0), 0, 0, 0, 0);
    step(0, nul, 1, 1, 32'hC000, 0);
    step(0, nul, 0, 0, 0, 1);
    chk("t6_flush",   bus.flush, 0);
    chk("t6_perf_br", bus.perf_branches, 0);
    chk("t6_pred_rdy", bus.pred_ready, 1);
    for (int i = 0; i < 3; i++) step(0, nul, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic        rt;
      logic [31:0] rtg;
      rec_t        r;
      r   = mk($urandom & 32'hFFFC, 1'($urandom), 32'h100 * $urandom_range(0, 3));
      rt  = 1'($urandom);
      rtg = 32'h100 * $urandom_range(0, 3);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        rt  = q[0].taken;
        rtg = q[0].target;
      end
      step(1'($urandom_range(0, 2) != 0), r, 1'($urandom_range(0, 1)), rt, rtg,
           $urandom_range(0, 199) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_verify_unit.md
Name: branch_verify_unit

Overview:
- Consumer-side end of the branch-prediction loop; sits between fetch/decode and execute.
- Queues every BPU prediction record issued with a fetched branch.
- Pops the oldest record when execute resolves that branch and compares predicted against actual outcome.
- Drives the verify bus back to the BPU (BHT update, correction) and a pipeline flush on mispredict.

Parameters:
DEPTH, 8, prediction-queue entries (power of two, >=2)
ENTRY_W, 58, width of the opaque BHT entry carried with each prediction (tag 21 + target 32 + br_type 3 + count 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
pred_valid  in  1  fetch offers a prediction record for a branch entering the pipe
pred_ready  out  1  record accepted when pred_valid && pred_ready
pred_pc  in  32  branch PC
pred_taken  in  1  predicted direction
pred_target  in  32  predicted target
pred_entry  in  ENTRY_W  BHT entry read at prediction time
res_valid  in  1  execute resolves the oldest outstanding branch (program order)
res_ready  out  1  resolution consumed when res_valid && res_ready
res_taken  in  1  actual direction
res_target  in  32  actual taken target
vfy_ready  out  1  one-cycle pulse: verify result valid
vfy_pc  out  32  PC of verified branch
vfy_success  out  1  prediction correct
vfy_taken  out  1  actual direction
vfy_target  out  32  correct next PC
vfy_entry  out  ENTRY_W  stored BHT entry, passed through unchanged
flush  out  1  one-cycle pulse, same cycle as vfy_ready with vfy_success=0
perf_branches  out  32  count of verified branches, wraps
perf_mispredicts  out  32  count of mispredicts, wraps

Behaviour:
- Reset: queue empty, state IDLE. All outputs 0 except pred_ready=1; res_ready=0 because the queue is empty. Both counters 0.
- Queue: circular, read/write pointers with an extra wrap bit.
  - full = pointer index bits equal and wrap bits differ.
  - empty = pointers equal.
- States:
  - IDLE: normal operation.
  - HOLD: exactly one cycle, always returns to IDLE.
- pred_ready = ~full && state==IDLE. No bypass: a record enqueued in cycle N is poppable in cycle N+1.
- res_ready = ~empty && state==IDLE. Execute holds res_valid until accepted.
- When full in IDLE, a simultaneous pop and enqueue are both allowed only if pred_ready was high, which it is not when full. Enqueue is therefore refused that cycle.
- On resolve accept in cycle N, compare against the head record:
  - success = (pred_taken==res_taken) && (~res_taken || pred_target==res_target)
  - correct target = res_taken ? res_target : pred_pc+8 (32-bit modulo)
- Results are registered and appear in cycle N+1 with vfy_ready=1 for one cycle only; vfy_* fields hold their value otherwise.
- Correct prediction: head is popped; state stays IDLE.
- Mispredict:
  - Head is popped and all younger entries are discarded (write pointer := read pointer + 1).
  - A pred_valid accepted in the same cycle N is also discarded, because it is wrong-path.
  - flush=1 in N+1; state becomes HOLD in N+1, back to IDLE in N+2.
  - During HOLD, pred_ready=0 and res_ready=0. This matches the BPU correction window, which ignores a verify arriving during it.
- Counters:
  - perf_branches increments on every vfy_ready.
  - perf_mispredicts increments when vfy_ready && ~vfy_success.
  - Both wrap at 2^32.
- Reset asserted mid-operation (including during HOLD or with a pending result) clears everything within that cycle. No vfy_ready or flush is emitted afterwards.

Decomposition:
- Shared cpu package holds:
  - predict-record struct (pc, taken, target, entry)
  - verify_result_t, with fields ordered to match the BPU verify bus
  - BHT_entry_t, branch-type enum, IDLE/HOLD constants
- Sub-module branch_info_fifo: parameterised circular queue with push, pop, flush-to-head and full/empty outputs.
- The compare logic, FSM and counters stay in the top module.

Test Plan:
- Correct not-taken: push pc=0x1000, taken=0; resolve taken=0 -> next cycle vfy_ready=1, success=1, target=0x1008, flush=0, perf_branches=1.
- Wrong target: push pc=0x2000, taken=1, target=0x3000; resolve taken=1, target=0x3400 -> success=0, target=0x3400, flush=1, res_ready/pred_ready low one cycle, perf_mispredicts=1.
- Flush younger: push 3 records; first mispredicts -> queue empty after flush; a 4th push in the resolve cycle is dropped; res_ready=0 until a new push.
- Full: push 8 records with no resolves -> pred_ready=0 on the 9th; one resolve -> pred_ready=1 the following cycle; pointer wrap verified over 20 push/pop pairs.
- Back-to-back correct: 4 consecutive successful resolves -> 4 consecutive vfy_ready pulses, no HOLD.
- Reset during HOLD: mispredict, then reset the next cycle -> all outputs at reset values, counters 0, no further flush.
